// File: rtl/ads5404_pkg.sv
// rtl/ads5404_pkg.sv - state encodings and default timing constants for the ADS5404 bring-up sequencer
package ads5404_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RST    = 3'd1,
      ST_LOCK   = 3'd2,
      ST_SYNC   = 3'd3,
      ST_SETTLE = 3'd4,
      ST_RUN    = 3'd5,
      ST_FAULT  = 3'd6,
      ST_UNUSED = 3'd7
   } state_e;

   localparam int RST_CYCLES_DEF    = 1024;
   localparam int LOCK_TIMEOUT_DEF  = 65536;
   localparam int SYNC_CYCLES_DEF   = 16;
   localparam int SETTLE_CYCLES_DEF = 256;
   localparam int MAX_RETRY_DEF     = 3;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/ads5404_seq_sync_2ff.sv
// rtl/ads5404_seq_sync_2ff.sv - two-flop synchroniser for a single asynchronous level
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         q_o    <= 1'b0;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end

endmodule

// File: rtl/ads5404_seq.sv
// rtl/ads5404_seq.sv - ADS5404 datapath bring-up sequencer: reset, PLL lock, sync, settle, run
module ads5404_seq
   import ads5404_pkg::*;
#(
   parameter int RST_CYCLES    = RST_CYCLES_DEF,
   parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
   parameter int SYNC_CYCLES   = SYNC_CYCLES_DEF,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int MAX_RETRY     = MAX_RETRY_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       resync,
   input  logic       pll_locked,
   output logic       user_rst,
   output logic       user_enable,
   output logic       user_sync,
   output logic       ready,
   output logic       fault,
   output logic [2:0] state,
   output logic [7:0] unlock_cnt
);

   localparam int TW = $clog2(max4(RST_CYCLES, LOCK_TIMEOUT, SYNC_CYCLES, SETTLE_CYCLES)) + 1;
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam logic [RW-1:0] RETRY_SAT = RW'(MAX_RETRY);

   state_e          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [RW-1:0]   retry_q, retry_d, retry_inc;
   logic [7:0]      unlock_d;
   logic            lock_s;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (pll_locked),
      .q_o   (lock_s)
   );

   assign retry_inc = (retry_q == RETRY_SAT) ? retry_q : retry_q + 1'b1;

   // Case order inside each state encodes stop > lock loss/timeout > resync > start.
   always_comb begin
      state_d  = state_q;
      retry_d  = retry_q;
      unlock_d = unlock_cnt;
      if (stop) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start) begin
               state_d = ST_RST;
               retry_d = '0;
            end
            ST_RST: if (timer_q == '0) state_d = ST_LOCK;
            ST_LOCK: begin
               if (lock_s) begin
                  state_d = ST_SYNC;
               end else if (timer_q == '0) begin
                  retry_d = retry_inc;
                  state_d = (int'(retry_q) + 1 < MAX_RETRY) ? ST_RST : ST_FAULT;
               end
            end
            ST_SYNC: if (timer_q == '0) state_d = ST_SETTLE;
            ST_SETTLE: begin
               if (!lock_s)              state_d = ST_RST;
               else if (timer_q == '0)   state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state_d  = ST_RST;
                  retry_d  = retry_inc;
                  unlock_d = (unlock_cnt == 8'hFF) ? unlock_cnt : unlock_cnt + 8'd1;
               end else if (resync) begin
                  state_d = ST_SYNC;
               end
            end
            ST_FAULT: if (start) begin
               state_d = ST_RST;
               retry_d = '0;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Loading value-1 on entry makes each timed state last exactly its parameter in cycles.
   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q) begin
         case (state_d)
            ST_RST:    timer_d = TW'(RST_CYCLES - 1);
            ST_LOCK:   timer_d = TW'(LOCK_TIMEOUT - 1);
            ST_SYNC:   timer_d = TW'(SYNC_CYCLES - 1);
            ST_SETTLE: timer_d = TW'(SETTLE_CYCLES - 1);
            default:   timer_d = '0;
         endcase
      end else if (timer_q != '0) begin
         timer_d = timer_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         retry_q     <= '0;
         unlock_cnt  <= 8'd0;
         user_rst    <= 1'b1;
         user_enable <= 1'b0;
         user_sync   <= 1'b0;
         ready       <= 1'b0;
         fault       <= 1'b0;
         state       <= 3'd0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         retry_q     <= retry_d;
         unlock_cnt  <= unlock_d;
         user_rst    <= !(state_q inside {ST_LOCK, ST_SYNC, ST_SETTLE, ST_RUN});
         user_enable <= state_q inside {ST_RST, ST_LOCK, ST_SYNC, ST_SETTLE, ST_RUN};
         user_sync   <= (state_q == ST_SYNC);
         ready       <= (state_q == ST_RUN);
         fault       <= (state_q == ST_FAULT);
         state       <= state_q;
      end
   end

endmodule
